// File: rtl/key_search_pkg.sv
// Shared types and the character-class screen for the multi-lane key search.
package key_search_pkg;

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_FOUND, G_EXHAUSTED} glob_state_e;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WAIT_CHAR, L_DONE} lane_state_e;

    localparam logic [7:0] CHAR_SPACE = 8'd32;
    localparam logic [7:0] LOWER_A    = 8'd97;
    localparam logic [7:0] LOWER_Z    = 8'd122;
    localparam logic [7:0] PRINT_MAX  = 8'd126;

    // mode 0: lowercase letters or space; mode 1: any printable ASCII
    function automatic logic char_ok(input logic [7:0] ch, input logic mode);
        if (mode)
            return (ch >= CHAR_SPACE) && (ch <= PRINT_MAX);
        return (ch == CHAR_SPACE) || ((ch >= LOWER_A) && (ch <= LOWER_Z));
    endfunction

endpackage

// File: rtl/key_search_lane.sv
// One search lane: owns its key, screens its core's bytes and pulses a restart
// whenever it moves on to the next interleaved key.
module key_search_lane
    import key_search_pkg::*;
#(
    parameter int                KEY_W     = 24,
    parameter int                NUM_CORES = 4,
    parameter int                MSG_LEN   = 32,
    parameter logic [KEY_W-1:0]  KEY_START = '0,
    parameter logic [KEY_W-1:0]  KEY_MAX   = '1,
    parameter int                LANE      = 0
) (
    input  logic             clok,
    input  logic             resetm,
    input  logic             init_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic             valid_i,
    input  logic [7:0]       data_i,
    input  logic [5:0]       idx_i,
    output logic [KEY_W-1:0] key_o,
    output logic             restart_o,
    output logic             pass_o,
    output logic             reject_o,
    output logic             done_o
);

    localparam logic [KEY_W:0] KEY_MAX_W  = {1'b0, KEY_MAX};
    localparam logic [KEY_W:0] KEY_INIT_W = {1'b0, KEY_START} + (KEY_W+1)'(LANE);
    localparam logic [KEY_W:0] KEY_STEP_W = (KEY_W+1)'(NUM_CORES);
    localparam logic [6:0]     MSG_LEN_W  = 7'(MSG_LEN);

    lane_state_e      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W:0]   key_next;
    logic             in_msg, is_last, byte_ok, sampling;

    // One extra bit so stepping past the top of the key space is detectable
    assign key_next = {1'b0, key_q} + KEY_STEP_W;
    assign in_msg   = {1'b0, idx_i} < MSG_LEN_W;
    assign is_last  = {1'b0, idx_i} == (MSG_LEN_W - 7'd1);
    assign byte_ok  = char_ok(data_i, mode_i);
    assign sampling = (state_q == L_WAIT_CHAR) && valid_i && in_msg;

    assign pass_o    = sampling && byte_ok && is_last;
    assign reject_o  = sampling && !byte_ok;
    assign restart_o = (state_q == L_LOAD);
    assign done_o    = (state_q == L_DONE);
    assign key_o     = key_q;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        if (init_i) begin
            key_d   = KEY_INIT_W[KEY_W-1:0];
            state_d = (KEY_INIT_W > KEY_MAX_W) ? L_DONE : L_LOAD;
        end else if (stop_i) begin
            state_d = L_IDLE;
        end else begin
            case (state_q)
                L_LOAD:      state_d = L_WAIT_CHAR;
                L_WAIT_CHAR: begin
                    if (reject_o) begin
                        if (key_next <= KEY_MAX_W) begin
                            key_d   = key_next[KEY_W-1:0];
                            state_d = L_LOAD;
                        end else begin
                            state_d = L_DONE;
                        end
                    end
                end
                default:     state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clok or negedge resetm) begin
        if (!resetm) begin
            state_q <= L_IDLE;
            key_q   <= KEY_INIT_W[KEY_W-1:0];
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: rtl/key_search_ctrl.sv
// Multi-lane key search controller: global FSM, winner select and the
// saturating rejected-key count over NUM_CORES interleaved lanes.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int               NUM_CORES = 4,
    parameter int               KEY_W     = 24,
    parameter int               MSG_LEN   = 32,
    parameter logic [KEY_W-1:0] KEY_START = '0,
    parameter logic [KEY_W-1:0] KEY_MAX   = KEY_W'(24'h3FFFFF)
) (
    input  logic                       clok,
    input  logic                       resetm,
    input  logic                       start,
    input  logic                       char_mode,
    input  logic [NUM_CORES-1:0]       char_valid,
    input  logic [8*NUM_CORES-1:0]     char_data,
    input  logic [6*NUM_CORES-1:0]     char_idx,
    output logic [KEY_W*NUM_CORES-1:0] core_key,
    output logic [NUM_CORES-1:0]       core_restart,
    output logic                       busy,
    output logic                       found,
    output logic [KEY_W-1:0]           found_key,
    output logic [2:0]                 found_core,
    output logic                       exhausted,
    output logic [KEY_W:0]             keys_rejected
);

    glob_state_e          state_q, state_d;
    logic                 mode_q, mode_d;
    logic [KEY_W-1:0]     found_key_q, found_key_d;
    logic [2:0]           found_core_q, found_core_d;
    logic [KEY_W:0]       rejected_q, rejected_d;
    logic [NUM_CORES-1:0] pass, reject, done;
    logic [KEY_W-1:0]     win_key;
    logic [2:0]           win_core;
    logic                 init, stop;

    function automatic logic [3:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_CORES; i++)
            c = c + 4'(v[i]);
        return c;
    endfunction

    function automatic logic [KEY_W:0] sat_add(input logic [KEY_W:0] a, input logic [3:0] b);
        logic [KEY_W+1:0] s;
        s = {1'b0, a} + (KEY_W+2)'(b);
        return s[KEY_W+1] ? '1 : s[KEY_W:0];
    endfunction

    // A start outside RUN re-initialises every lane, including after FOUND/EXHAUSTED
    assign init = start && (state_q != G_RUN);
    assign stop = (state_q == G_RUN) && (|pass);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        key_search_lane #(
            .KEY_W     (KEY_W),
            .NUM_CORES (NUM_CORES),
            .MSG_LEN   (MSG_LEN),
            .KEY_START (KEY_START),
            .KEY_MAX   (KEY_MAX),
            .LANE      (i)
        ) u_lane (
            .clok      (clok),
            .resetm    (resetm),
            .init_i    (init),
            .stop_i    (stop),
            .mode_i    (mode_q),
            .valid_i   (char_valid[i]),
            .data_i    (char_data[8*i +: 8]),
            .idx_i     (char_idx[6*i +: 6]),
            .key_o     (core_key[KEY_W*i +: KEY_W]),
            .restart_o (core_restart[i]),
            .pass_o    (pass[i]),
            .reject_o  (reject[i]),
            .done_o    (done[i])
        );
    end

    // Scan downward so the lowest passing lane wins
    always_comb begin
        win_key  = '0;
        win_core = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pass[i]) begin
                win_key  = core_key[KEY_W*i +: KEY_W];
                win_core = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        found_key_d  = found_key_q;
        found_core_d = found_core_q;
        rejected_d   = rejected_q;
        case (state_q)
            G_RUN: begin
                rejected_d = sat_add(rejected_q, popcount(reject));
                if (|pass) begin
                    state_d      = G_FOUND;
                    found_key_d  = win_key;
                    found_core_d = win_core;
                end else if (&done) begin
                    state_d = G_EXHAUSTED;
                end
            end
            default: begin
                if (start) begin
                    state_d      = G_RUN;
                    mode_d       = char_mode;
                    found_key_d  = '0;
                    found_core_d = '0;
                    rejected_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clok or negedge resetm) begin
        if (!resetm) begin
            state_q      <= G_IDLE;
            mode_q       <= 1'b0;
            found_key_q  <= '0;
            found_core_q <= '0;
            rejected_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            found_key_q  <= found_key_d;
            found_core_q <= found_core_d;
            rejected_q   <= rejected_d;
        end
    end

    assign busy          = (state_q == G_RUN);
    assign found         = (state_q == G_FOUND);
    assign exhausted     = (state_q == G_EXHAUSTED);
    assign found_key     = found_key_q;
    assign found_core    = found_core_q;
    assign keys_rejected = rejected_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: class table, hand-written corner sequences and a
// randomized run against a behavioural model of the search on a small key space.
module tb_key_search_ctrl;

    localparam int N    = 4;
    localparam int KW   = 24;
    localparam int ML   = 32;
    localparam int XMAX = 5;

    logic            clok = 1'b0;
    logic            resetm = 1'b0;
    logic            start = 1'b0;
    logic            char_mode = 1'b0;
    logic [N-1:0]    char_valid = '0;
    logic [8*N-1:0]  char_data = '0;
    logic [6*N-1:0]  char_idx = '0;

    logic [KW*N-1:0] core_key, x_core_key;
    logic [N-1:0]    core_restart, x_core_restart;
    logic            busy, found, exhausted, x_busy, x_found, x_exhausted;
    logic [KW-1:0]   found_key, x_found_key;
    logic [2:0]      found_core, x_found_core;
    logic [KW:0]     keys_rejected, x_keys_rejected;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clok = ~clok;

    key_search_ctrl #(.NUM_CORES(N), .KEY_W(KW), .MSG_LEN(ML)) dut (
        .clok(clok), .resetm(resetm), .start(start), .char_mode(char_mode),
        .char_valid(char_valid), .char_data(char_data), .char_idx(char_idx),
        .core_key(core_key), .core_restart(core_restart), .busy(busy),
        .found(found), .found_key(found_key), .found_core(found_core),
        .exhausted(exhausted), .keys_rejected(keys_rejected)
    );

    key_search_ctrl #(.NUM_CORES(N), .KEY_W(KW), .MSG_LEN(ML), .KEY_MAX(24'd5)) dut_x (
        .clok(clok), .resetm(resetm), .start(start), .char_mode(char_mode),
        .char_valid(char_valid), .char_data(char_data), .char_idx(char_idx),
        .core_key(x_core_key), .core_restart(x_core_restart), .busy(x_busy),
        .found(x_found), .found_key(x_found_key), .found_core(x_found_core),
        .exhausted(x_exhausted), .keys_rejected(x_keys_rejected)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KW*N-1:0] keys(input int k0, input int k1, input int k2, input int k3);
        return {KW'(k3), KW'(k2), KW'(k1), KW'(k0)};
    endfunction

    task automatic tick();
        @(negedge clok);
    endtask

    task automatic do_reset();
        start = 1'b0;
        char_valid = '0;
        resetm = 1'b0;
        tick();
        tick();
        resetm = 1'b1;
        tick();
    endtask

    task automatic do_start(input logic mode);
        char_mode = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic put(input int lane, input logic [7:0] b, input logic [5:0] idx);
        char_valid[lane] = 1'b1;
        char_data[8*lane +: 8] = b;
        char_idx[6*lane +: 6] = idx;
    endtask

    task automatic send();
        tick();
        char_valid = '0;
    endtask

    // ---------------- behavioural model of the small key-space instance
    int  m_key [N];
    bit  m_alive [N];
    bit  m_load [N];
    bit  m_run, m_found, m_exh, m_mode;
    int  m_fkey, m_fcore;
    longint m_rej;

    function automatic bit ref_ok(input int b, input bit mode);
        if (mode) return (b >= 32) && (b <= 126);
        return (b == 32) || ((b >= 97) && (b <= 122));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_key[i] = i;
            m_alive[i] = 0;
            m_load[i] = 0;
        end
        m_run = 0; m_found = 0; m_exh = 0; m_mode = 0;
        m_fkey = 0; m_fcore = 0; m_rej = 0;
    endtask

    task automatic model_edge();
        bit rej_now [N];
        bit any_pass;
        bit all_dead;
        int win;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_found = 0; m_exh = 0; m_fkey = 0; m_fcore = 0; m_rej = 0;
                m_mode = char_mode;
                for (int i = 0; i < N; i++) begin
                    m_key[i] = i;
                    m_alive[i] = (i <= XMAX);
                    m_load[i] = m_alive[i];
                end
            end
            return;
        end
        all_dead = 1;
        any_pass = 0;
        win = 0;
        for (int i = 0; i < N; i++) if (m_alive[i]) all_dead = 0;
        for (int i = 0; i < N; i++) begin
            int b, k;
            rej_now[i] = 0;
            b = int'(char_data[8*i +: 8]);
            k = int'(char_idx[6*i +: 6]);
            if (m_alive[i] && !m_load[i] && char_valid[i] && k < ML) begin
                if (!ref_ok(b, m_mode)) begin
                    rej_now[i] = 1;
                    m_rej++;
                end else if (k == ML - 1) begin
                    if (!any_pass) win = i;
                    any_pass = 1;
                end
            end
        end
        if (m_rej > 64'h1FF_FFFF) m_rej = 64'h1FF_FFFF;
        for (int i = 0; i < N; i++) m_load[i] = 0;
        if (any_pass) begin
            m_found = 1; m_run = 0; m_fkey = m_key[win]; m_fcore = win;
            for (int i = 0; i < N; i++) m_alive[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rej_now[i]) begin
                    if (m_key[i] + N <= XMAX) begin
                        m_key[i] += N;
                        m_load[i] = 1;
                    end else begin
                        m_alive[i] = 0;
                    end
                end
            end
            if (all_dead) begin
                m_exh = 1; m_run = 0;
            end
        end
    endtask

    typedef struct {
        logic       mode;
        logic [7:0] b;
        logic       ok;
    } vec_t;

    vec_t vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [8];
        vt[0]  = '{1'b0, 8'h61, 1'b1};  // 'a'
        vt[1]  = '{1'b0, 8'h7A, 1'b1};  // 'z'
        vt[2]  = '{1'b0, 8'h20, 1'b1};  // space
        vt[3]  = '{1'b0, 8'h7B, 1'b0};  // '{'
        vt[4]  = '{1'b0, 8'h60, 1'b0};  // '`'
        vt[5]  = '{1'b0, 8'h41, 1'b0};  // 'A'
        vt[6]  = '{1'b1, 8'h7E, 1'b1};  // '~'
        vt[7]  = '{1'b1, 8'h7F, 1'b0};  // DEL
        vt[8]  = '{1'b1, 8'h20, 1'b1};
        vt[9]  = '{1'b1, 8'h1F, 1'b0};
        vt[10] = '{1'b1, 8'h41, 1'b1};
        vt[11] = '{1'b0, 8'h21, 1'b0};  // '!'

        // reset state
        tick();
        chk("rst core_key", core_key, keys(0, 1, 2, 3));
        chk("rst core_restart", core_restart, 0);
        chk("rst busy/found/exh", {busy, found, exhausted}, 0);
        chk("rst found_key/core", {found_key, found_core}, 0);
        chk("rst keys_rejected", keys_rejected, 0);

        // lane 2 passes a full message
        do_reset();
        do_start(1'b0);
        chk("t1 busy", busy, 1);
        chk("t1 restart all", core_restart, 4'hF);
        chk("t1 keys", core_key, keys(0, 1, 2, 3));
        tick();
        chk("t1 restart one cycle", core_restart, 0);
        for (int k = 0; k < ML; k++) begin
            put(2, 8'h61, 6'(k));
            send();
            if (k == ML - 2) chk("t1 not yet found", found, 0);
        end
        chk("t1 found", found, 1);
        chk("t1 found_key", found_key, 2);
        chk("t1 found_core", found_core, 2);
        chk("t1 busy", busy, 0);
        chk("t1 rejected", keys_rejected, 0);
        tick();
        chk("t1 found sticky", found, 1);
        chk("t1 no restart", core_restart, 0);

        // single and simultaneous rejections, ignored bytes, ignored start
        do_reset();
        do_start(1'b0);
        tick();
        put(0, 8'h41, 6'd3);
        send();
        chk("t2 keys", core_key, keys(4, 1, 2, 3));
        chk("t2 restart", core_restart, 4'b0001);
        chk("t2 rejected", keys_rejected, 1);
        tick();
        chk("t2 restart drops", core_restart, 0);
        put(1, 8'h41, 6'd0);
        put(3, 8'h21, 6'd5);
        send();
        chk("t3 rejected", keys_rejected, 3);
        chk("t3 keys", core_key, keys(4, 5, 2, 7));
        chk("t3 restart", core_restart, 4'b1010);
        put(1, 8'h41, 6'd0);
        put(2, 8'h41, 6'd40);
        send();
        chk("ignored bytes rejected", keys_rejected, 3);
        chk("ignored bytes keys", core_key, keys(4, 5, 2, 7));
        do_start(1'b1);
        chk("start in run busy", busy, 1);
        chk("start in run restart", core_restart, 0);
        chk("start in run rejected", keys_rejected, 3);
        put(0, 8'h7E, 6'd0);
        send();
        chk("mode kept rejected", keys_rejected, 4);
        chk("mode kept keys", core_key, keys(8, 5, 2, 7));

        // exhaustion with KEY_MAX=5
        do_reset();
        do_start(1'b0);
        tick();
        for (int i = 0; i < N; i++) put(i, 8'h41, 6'd0);
        send();
        chk("t4 rejected 4", x_keys_rejected, 4);
        chk("t4 keys", x_core_key, keys(4, 5, 2, 3));
        chk("t4 restart", x_core_restart, 4'b0011);
        chk("t4 not exhausted", x_exhausted, 0);
        tick();
        put(0, 8'h41, 6'd0);
        put(1, 8'h41, 6'd0);
        send();
        chk("t4 rejected 6", x_keys_rejected, 6);
        chk("t4 keys final", x_core_key, keys(4, 5, 2, 3));
        begin
            int w;
            w = 0;
            while (!x_exhausted && w < 5) begin
                tick();
                w++;
            end
        end
        chk("t4 exhausted", x_exhausted, 1);
        chk("t4 found", x_found, 0);
        chk("t4 busy", x_busy, 0);
        chk("t4 restart none", x_core_restart, 0);

        // simultaneous pass: lowest lane wins; then restart from FOUND
        do_reset();
        do_start(1'b0);
        tick();
        put(0, 8'h61, 6'(ML - 1));
        put(1, 8'h62, 6'(ML - 1));
        send();
        chk("t5 found", found, 1);
        chk("t5 found_core", found_core, 0);
        chk("t5 found_key", found_key, 0);
        do_start(1'b1);
        chk("t5 restart found clr", found, 0);
        chk("t5 restart busy", busy, 1);
        chk("t5 restart lanes", core_restart, 4'hF);

        // character-class table
        for (int i = 0; i < 12; i++) begin
            do_reset();
            do_start(vt[i].mode);
            tick();
            put(0, vt[i].b, 6'd3);
            send();
            chk($sformatf("class%0d rejected", i), keys_rejected, vt[i].ok ? 1'b0 : 1'b1);
            chk($sformatf("class%0d key0", i), core_key[KW-1:0], vt[i].ok ? 0 : 4);
            chk($sformatf("class%0d restart", i), core_restart, vt[i].ok ? 4'b0000 : 4'b0001);
        end

        // asynchronous reset mid-search
        do_reset();
        do_start(1'b0);
        tick();
        put(0, 8'h41, 6'd0);
        send();
        #2 resetm = 1'b0;
        #1;
        chk("t6 async keys", core_key, keys(0, 1, 2, 3));
        chk("t6 async flags", {busy, found, exhausted, core_restart}, 0);
        chk("t6 async rejected", keys_rejected, 0);
        tick();
        resetm = 1'b1;
        tick();
        do_start(1'b0);
        chk("t6 restart keys", core_key, keys(0, 1, 2, 3));
        chk("t6 restart lanes", core_restart, 4'hF);

        // randomized run against the model on the KEY_MAX=5 instance
        pool[0] = 8'h61; pool[1] = 8'h7A; pool[2] = 8'h20; pool[3] = 8'h41;
        pool[4] = 8'h7E; pool[5] = 8'h7F; pool[6] = 8'h7B; pool[7] = 8'h21;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!m_run && $urandom_range(0, 3) == 0) start = 1'b1;
            else start = ($urandom_range(0, 31) == 0);
            char_mode = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                char_valid[i] = 1'($urandom);
                char_data[8*i +: 8] = pool[$urandom_range(0, 7)];
                char_idx[6*i +: 6] = ($urandom_range(0, 3) == 0) ? 6'(ML - 1) : 6'($urandom_range(0, 40));
            end
            model_edge();
            tick();
            begin
                logic [KW*N-1:0] ek;
                logic [N-1:0]    er;
                for (int i = 0; i < N; i++) begin
                    ek[KW*i +: KW] = KW'(m_key[i]);
                    er[i] = m_load[i];
                end
                chk($sformatf("rnd%0d keys", cyc), x_core_key, ek);
                chk($sformatf("rnd%0d restart", cyc), x_core_restart, er);
                chk($sformatf("rnd%0d busy/found/exh", cyc), {x_busy, x_found, x_exhausted}, {m_run, m_found, m_exh});
                chk($sformatf("rnd%0d winner", cyc), {x_found_key, x_found_core}, {KW'(m_fkey), 3'(m_fcore)});
                chk($sformatf("rnd%0d rejected", cyc), x_keys_rejected, (KW+1)'(m_rej));
            end
        end
        start = 1'b0;
        char_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
